// File: rtl/output_stream_ctrl.sv
// Purpose: sequences one IFFT frame from the sample buffer onto a valid/ready stream.
// Latency: store one cycle after ifft_done; first sample one cycle after buf_ready; 1 sample/cycle sustained.
// Backpressure: out_ready low holds out_valid, data, read_addr and out_last stable; no bubbles on acceptance.
// Ports:
//   clk, reset_n           clock, async active-low reset (deassertion synchronised internally)
//   ifft_done              one-cycle pulse: IFFT frame present on buffer inputs
//   buf_ready, buf_real/imag  buffer status and flattened sample arrays (sample i at [i*DATA_WIDTH +: DATA_WIDTH])
//   store, read_en, read_addr, read_done  buffer control
//   out_valid/out_ready, out_real/imag, out_last  sample stream
//   busy, overrun, clr_err, frame_cnt  status, sticky error, error clear, completed-frame counter
module output_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ifft_done,
  input  logic                    buf_ready,
  input  logic [N*DATA_WIDTH-1:0] buf_real,
  input  logic [N*DATA_WIDTH-1:0] buf_imag,
  output logic                    store,
  output logic                    read_en,
  output logic [ADDR_W-1:0]       read_addr,
  output logic                    read_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_real,
  output logic [DATA_WIDTH-1:0]   out_imag,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        frame_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STORE    = 3'd1,
    WAIT_RDY = 3'd2,
    STREAM   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // idx is one bit wider than an address so the final-sample compare is unambiguous.
  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // Unflatten the buffer outputs so samples can be selected by address.
  logic [DATA_WIDTH-1:0] re_arr [N];
  logic [DATA_WIDTH-1:0] im_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign re_arr[g] = buf_real[g*DATA_WIDTH +: DATA_WIDTH];
    assign im_arr[g] = buf_imag[g*DATA_WIDTH +: DATA_WIDTH];
  end

  state_t                state_q;
  logic [ADDR_W:0]       idx_q;
  logic [ADDR_W:0]       idx_d;
  logic                  store_q;
  logic                  read_en_q;
  logic [ADDR_W-1:0]     read_addr_q;
  logic                  read_done_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_real_q;
  logic [DATA_WIDTH-1:0] out_imag_q;
  logic                  out_last_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic [CNT_W-1:0]      frame_cnt_q;

  assign idx_d = idx_q + IDX_ONE;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      store_q     <= 1'b0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      read_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // A new frame while one is in flight is dropped and flagged; set beats clear.
      if (ifft_done && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (clr_err)                   overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ifft_done) begin
            state_q <= STORE;
            store_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        STORE: begin
          store_q <= 1'b0;
          state_q <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (buf_ready) begin
            state_q     <= STREAM;
            idx_q       <= '0;
            read_addr_q <= '0;
            out_real_q  <= re_arr[0];
            out_imag_q  <= im_arr[0];
            out_valid_q <= 1'b1;
            read_en_q   <= 1'b1;
            out_last_q  <= (N == 1);
          end
        end
        STREAM: begin
          // buf_ready is deliberately ignored here: the frame is ours until read_done.
          if (out_valid_q && out_ready) begin
            if (idx_q == IDX_LAST) begin
              state_q     <= RELEASE;
              out_valid_q <= 1'b0;
              read_en_q   <= 1'b0;
              out_last_q  <= 1'b0;
              read_done_q <= 1'b1;
            end else begin
              // Preload the next sample on the accepting edge for zero-bubble streaming.
              idx_q       <= idx_d;
              read_addr_q <= idx_d[ADDR_W-1:0];
              out_real_q  <= re_arr[idx_d[ADDR_W-1:0]];
              out_imag_q  <= im_arr[idx_d[ADDR_W-1:0]];
              out_last_q  <= (idx_d == IDX_LAST);
            end
          end
        end
        RELEASE: begin
          read_done_q <= 1'b0;
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign store     = store_q;
  assign read_en   = read_en_q;
  assign read_addr = read_addr_q;
  assign read_done = read_done_q;
  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/output_stream_ctrl.md
Name: output_stream_ctrl

Overview:
- Sequencer sitting between the IFFT core, the output sample buffer and the downstream chiplet link.
- On an IFFT-complete pulse it commands the buffer to latch a frame, then streams the N complex samples out in address order over a valid/ready interface.
- It then signals read completion back to the buffer.
- Also flags frame overruns and counts completed frames.

Parameters:
- DATA_WIDTH, 16, sample width (signed, two's complement).
- N, 16, samples per frame (power of two, ≥2).
- ADDR_W, 4, address width, equals log2(N).
- CNT_W, 8, frame counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ifft_done  in  1  one-cycle pulse, IFFT frame valid on buffer inputs.
- buf_ready  in  1  buffer holds a latched frame.
- buf_real  in  DATA_WIDTH x N  buffer real outputs.
- buf_imag  in  DATA_WIDTH x N  buffer imaginary outputs.
- store  out  1  buffer latch command.
- read_en  out  1  buffer read enable.
- read_addr  out  ADDR_W  current sample address.
- read_done  out  1  buffer release pulse.
- out_valid  out  1  stream sample valid.
- out_ready  in  1  downstream accepts sample.
- out_real  out  DATA_WIDTH  streamed real sample.
- out_imag  out  DATA_WIDTH  streamed imaginary sample.
- out_last  out  1  marks sample N-1.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: ifft_done received while busy.
- clr_err  in  1  clears overrun.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert to clk): state=IDLE; all outputs 0 (store, read_en, read_done, out_valid, out_last, busy, overrun, read_addr, out_real, out_imag, frame_cnt). Reset mid-frame aborts the frame immediately; no read_done is issued.
- FSM states: IDLE, STORE, WAIT_RDY, STREAM, RELEASE. All outputs are registered.
- IDLE: when ifft_done=1, go to STORE. In the cycle after ifft_done is sampled, store=1 and busy=1.
- STORE: store is high for exactly one cycle, then go to WAIT_RDY with store=0.
- WAIT_RDY: wait for buf_ready=1. Once seen, go to STREAM; idx=0; out_real/out_imag <= buf_real[0]/buf_imag[0]; out_valid=1; read_en=1; read_addr=0; out_last=(N==1 ? 1 : 0). There is no timeout.
- STREAM handshake: a transfer occurs when out_valid && out_ready. While out_ready=0, out_valid, data, read_addr and out_last hold stable.
  - On a transfer with idx<N-1: idx++, read_addr=idx+1, and the data registers load buf_[idx+1] in the same edge. The next sample is presented the very next cycle, so zero bubbles are allowed (1 sample/cycle sustained).
  - out_last=1 only while idx==N-1.
- On a transfer with idx==N-1: go to RELEASE; out_valid=0, read_en=0, out_last=0; read_done=1 for exactly one cycle.
- RELEASE: frame_cnt++ (wraps from 2^CNT_W-1 to 0), then go to IDLE; busy=0 in the next cycle.
- Overrun:
  - ifft_done while state≠IDLE sets overrun=1 next cycle; the pulse is otherwise ignored and the current frame is unaffected.
  - clr_err clears overrun. If clr_err and an overrun-causing ifft_done coincide, set wins.
- ifft_done in the RELEASE cycle counts as overrun (busy is still high). The upstream must wait for busy=0.
- read_addr wraps naturally and never exceeds N-1. idx is ADDR_W+1 bits internally to avoid wrap ambiguity.
- buf_ready dropping during STREAM is ignored; the controller owns the buffer until read_done.

Test Plan:
- Single frame, out_ready tied 1; buffer holds real[i]=i, imag[i]=-i. ifft_done@t0 -> store@t1; first out_valid one cycle after buf_ready; 16 consecutive samples 0..15 / 0..-15; out_last only on the 16th; read_done one cycle later; frame_cnt=1.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> exactly 16 transfers in order; data and read_addr stable during stalls; no duplicates or drops.
- Overrun: second ifft_done at sample 5 of a frame -> overrun=1, frame completes normally with 16 samples, no second store. clr_err -> overrun=0. Simultaneous clr_err and ifft_done while busy -> overrun stays 1.
- Delayed buf_ready (asserted 7 cycles after store) -> controller holds in WAIT_RDY with out_valid=0, then streams correctly.
- Reset mid-stream at sample 9 -> all outputs 0 asynchronously, no read_done. A fresh ifft_done after release starts a new frame at address 0.
- Frame counter wrap with CNT_W=2: 5 back-to-back frames -> frame_cnt sequence 1,2,3,0,1. Back-to-back: ifft_done issued the cycle busy falls is accepted with no overrun.
